// File: rtl/imm_gen_pipe_if.sv
// Handshake and payload bundle for imm_gen_pipe: upstream instruction/PC channel,
// flush, and downstream decoded-immediate channel.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_pc;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_target, out_pc
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_target, out_pc
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator: decodes format and immediate in one cycle and buffers
// results in a 2-entry skid buffer with a registered in_ready.
module imm_gen_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter bit          PC_ADD = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  imm_gen_pipe_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ISH = 3'd6,
    FMT_ILL = 3'd7
  } fmt_t;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } entry_t;

  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  state_t      state, state_next;
  entry_t      dec, out_q, skid_q;
  logic        in_ready_q;
  logic        accept, pop;
  logic        load_out, load_skid, out_from_skid;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  fmt_t        fmt;
  logic [XLEN-1:0] imm;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  always_comb begin
    fmt = FMT_ILL;
    imm = '0;
    case (opcode)
      7'b0110111, 7'b0010111: begin
        fmt = FMT_U;
        imm = sext32({instr[31:12], 12'b0});
      end
      7'b1101111: begin
        fmt = FMT_J;
        imm = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
      end
      7'b0010011: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          fmt = FMT_ISH;
          imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
        end else begin
          fmt = FMT_I;
          imm = sext32({{20{instr[31]}}, instr[31:20]});
        end
      end
      7'b1100111, 7'b0000011, 7'b1110011: begin
        fmt = FMT_I;
        imm = sext32({{20{instr[31]}}, instr[31:20]});
      end
      7'b0100011: begin
        fmt = FMT_S;
        imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
      end
      7'b1100011: begin
        fmt = FMT_B;
        imm = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
      end
      7'b0110011: begin
        fmt = FMT_R;
        imm = '0;
      end
      default: begin
        fmt = FMT_ILL;
        imm = '0;
      end
    endcase
  end

  always_comb begin
    dec        = '0;
    dec.imm    = imm;
    dec.fmt    = fmt;
    dec.pc     = bus.in_pc;
    dec.target = PC_ADD ? (bus.in_pc + imm) : '0;
  end

  assign accept = bus.in_valid && in_ready_q && !bus.flush;
  assign pop    = (state != EMPTY) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != TWO);
    end
  end

  always_comb begin
    state_next    = state;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          load_out   = 1'b1;
        end
      end
      ONE: begin
        if (accept && !pop) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (accept && pop) begin
          load_out = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_next    = ONE;
          out_from_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
    // Flush only redirects the state; stale register contents are hidden by out_valid.
    if (bus.flush) state_next = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out)           out_q <= dec;
      else if (out_from_skid) out_q <= skid_q;
      if (load_skid)          skid_q <= dec;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = (state != EMPTY);
  assign bus.out_imm    = out_q.imm;
  assign bus.out_fmt    = out_q.fmt;
  assign bus.out_pc     = out_q.pc;
  assign bus.out_target = out_q.target;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: vector table through a scoreboard, plus
// backpressure, flush, reset and XLEN=64 sequences.
module tb_imm_gen_pipe;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [31:0] target;
  } vec_t;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [31:0] pc;
    logic [31:0] target;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rst64_n;

  vec_t vecs[14];
  exp_t sbq[$];
  exp_t cur_exp;
  exp_t e;
  int   checks = 0;
  int   passes = 0;
  int   pops   = 0;

  imm_gen_pipe_if #(.XLEN(32)) b32();
  imm_gen_pipe_if #(.XLEN(64)) b64();

  imm_gen_pipe #(.XLEN(32), .PC_ADD(1'b1)) dut32 (.clk(clk), .rst_n(rst_n),   .bus(b32));
  imm_gen_pipe #(.XLEN(64), .PC_ADD(1'b1)) dut64 (.clk(clk), .rst_n(rst64_n), .bus(b64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: pop-compare, then flush clear, then push of the accepted input.
  always @(negedge clk) begin
    if (rst_n) begin
      if (b32.out_valid && b32.out_ready) begin
        pops++;
        if (sbq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_out: got imm %h pc %h, expected no output", b32.out_imm, b32.out_pc);
        end else begin
          e = sbq.pop_front();
          chk("out_imm",    b32.out_imm,    e.imm);
          chk("out_fmt",    b32.out_fmt,    e.fmt);
          chk("out_pc",     b32.out_pc,     e.pc);
          chk("out_target", b32.out_target, e.target);
        end
      end
      if (b32.flush) sbq.delete();
      if (b32.in_valid && b32.in_ready && !b32.flush) sbq.push_back(cur_exp);
    end
  end

  task automatic set_in(input vec_t v);
    b32.in_valid = 1'b1;
    b32.in_instr = v.instr;
    b32.in_pc    = v.pc;
    cur_exp      = '{imm: v.imm, fmt: v.fmt, pc: v.pc, target: v.target};
  endtask

  task automatic send(input vec_t v);
    int unsigned n;
    n = 0;
    set_in(v);
    @(negedge clk);
    while (!b32.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!b32.in_ready) begin
      checks++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((sbq.size() != 0 || b32.out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_queue", 64'(sbq.size()), 64'd0);
    chk("drain_valid", b32.out_valid, 1'b0);
  endtask

  initial begin
    time t0;
    int  p0;

    vecs[0]  = '{32'hFFF00093, 32'h0000_0000, 32'hFFFFFFFF, 3'd1, 32'hFFFFFFFF}; // addi -1
    vecs[1]  = '{32'h12345037, 32'h0000_0010, 32'h12345000, 3'd4, 32'h12345010}; // lui
    vecs[2]  = '{32'h00311093, 32'h0000_0020, 32'h00000003, 3'd6, 32'h00000023}; // slli 3
    vecs[3]  = '{32'hFE000EE3, 32'h0000_0100, 32'hFFFFFFFC, 3'd3, 32'h000000FC}; // beq -4
    vecs[4]  = '{32'h002081B3, 32'h0000_0200, 32'h00000000, 3'd0, 32'h00000200}; // add
    vecs[5]  = '{32'h0000000F, 32'h0000_0300, 32'h00000000, 3'd7, 32'h00000300}; // fence: illegal
    vecs[6]  = '{32'hFE112E23, 32'h0000_0400, 32'hFFFFFFFC, 3'd2, 32'h000003FC}; // sw -4
    vecs[7]  = '{32'h800000EF, 32'h0000_1000, 32'hFFF00000, 3'd5, 32'hFFF01000}; // jal min
    vecs[8]  = '{32'h00001097, 32'h0000_0500, 32'h00001000, 3'd4, 32'h00001500}; // auipc
    vecs[9]  = '{32'h40315093, 32'h0000_0600, 32'h00000003, 3'd6, 32'h00000603}; // srai 3
    vecs[10] = '{32'h80000067, 32'h0000_0700, 32'hFFFFF800, 3'd1, 32'hFFFFFF00}; // jalr -2048
    vecs[11] = '{32'h7FF02083, 32'hFFFF_FFFF, 32'h000007FF, 3'd1, 32'h000007FE}; // lw, target wraps
    vecs[12] = '{32'h30001073, 32'h0000_0000, 32'h00000300, 3'd1, 32'h00000300}; // csrrw
    vecs[13] = '{32'h03F11093, 32'h0000_0800, 32'h0000001F, 3'd6, 32'h0000081F}; // slli, bit25 ignored

    rst_n = 1'b0;  rst64_n = 1'b0;
    b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_pc = '0; b32.flush = 1'b0; b32.out_ready = 1'b0;
    b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_pc = '0; b64.flush = 1'b0; b64.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid",  b32.out_valid,  1'b0);
    chk("rst_in_ready",   b32.in_ready,   1'b0);
    chk("rst_out_imm",    b32.out_imm,    32'h0);
    chk("rst_out_target", b32.out_target, 32'h0);
    chk("rst_out_pc",     b32.out_pc,     32'h0);
    chk("rst_out_fmt",    b32.out_fmt,    3'd0);

    @(negedge clk);
    rst_n = 1'b1;  rst64_n = 1'b1;
    #1 chk("ready_before_edge", b32.in_ready, 1'b0);
    @(posedge clk); #1;
    chk("ready_after_edge", b32.in_ready, 1'b1);

    // Back-to-back table with the consumer always ready.
    b32.out_ready = 1'b1;
    t0 = $time;
    foreach (vecs[i]) send(vecs[i]);
    chk("throughput_time", 64'($time - t0), 64'(14 * 10));
    drain();

    // Backpressure: A and B fill the buffer, C waits.
    b32.out_ready = 1'b0;
    send(vecs[1]);
    send(vecs[3]);
    chk("ready_low_after_b", b32.in_ready, 1'b0);
    set_in(vecs[7]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", b32.out_valid, 1'b1);
      chk("stall_imm",   b32.out_imm,   vecs[1].imm);
      chk("stall_pc",    b32.out_pc,    vecs[1].pc);
      @(posedge clk); #1;
    end
    b32.out_ready = 1'b1;
    send(vecs[7]);
    drain();

    // Flush while full, with a valid input on the flush cycle.
    b32.out_ready = 1'b0;
    send(vecs[4]);
    send(vecs[5]);
    set_in(vecs[8]);
    b32.flush = 1'b1;
    @(posedge clk); #1;
    b32.flush = 1'b0;
    b32.in_valid = 1'b0;
    chk("flush_out_valid", b32.out_valid, 1'b0);
    chk("flush_in_ready",  b32.in_ready,  1'b1);
    b32.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("flush_stays_empty", b32.out_valid, 1'b0);
    chk("flush_queue", 64'(sbq.size()), 64'd0);

    // Flush in ONE together with a pop: the popped entry still transfers.
    b32.out_ready = 1'b0;
    send(vecs[9]);
    p0 = pops;
    b32.out_ready = 1'b1;
    b32.flush = 1'b1;
    @(posedge clk); #1;
    b32.flush = 1'b0;
    chk("flush_pop_count", 64'(pops - p0), 64'd1);
    chk("flush_pop_valid", b32.out_valid, 1'b0);
    drain();

    // XLEN=64: lui sign-extends from bit 31; async reset in ONE.
    @(posedge clk); #1;
    b64.in_valid = 1'b1; b64.in_instr = 32'h800000B7; b64.in_pc = 64'h1000;
    @(posedge clk); #1;
    b64.in_valid = 1'b0;
    chk("x64_valid",  b64.out_valid,  1'b1);
    chk("x64_imm",    b64.out_imm,    64'hFFFFFFFF80000000);
    chk("x64_fmt",    b64.out_fmt,    3'd4);
    chk("x64_target", b64.out_target, 64'hFFFFFFFF80001000);
    #2 rst64_n = 1'b0;
    #1;
    chk("x64_rst_valid", b64.out_valid, 1'b0);
    chk("x64_rst_ready", b64.in_ready,  1'b0);
    chk("x64_rst_imm",   b64.out_imm,   64'h0);
    @(negedge clk);
    rst64_n = 1'b1;
    @(posedge clk); #1;
    chk("x64_ready_back", b64.in_ready, 1'b1);
    b64.in_valid = 1'b1; b64.in_instr = 32'h03F11093; b64.in_pc = 64'hFFFFFFFFFFFFFFF0;
    @(posedge clk); #1;
    b64.in_valid = 1'b0;
    chk("x64_shamt_imm",    b64.out_imm,    64'h3F);
    chk("x64_shamt_fmt",    b64.out_fmt,    3'd6);
    chk("x64_shamt_target", b64.out_target, 64'h000000000000002F);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
